// File: rtl/music_box_input_conditioner.sv
// Music box input conditioner.
// Synchronizes, debounces and edge-detects the four active-low control
// buttons and six active-high music keys feeding the music box state
// controller. Debounced levels are registered; press/key events are
// single-cycle pulses one cycle after the debounced level changes.
// Optional build macro: MUSICBOX_INPUT_LOCKOUT_EN -- the first debounced
// button press owns the button group and masks the other buttons until
// the owner is released (music keys are never masked).
module music_box_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock_50Mhz,
  input  logic       reset_n,
  input  logic       raw_PlaySong0_n,
  input  logic       raw_PlaySong1_n,
  input  logic       raw_PlayRecording_n,
  input  logic       raw_MakeRecording_n,
  input  logic [5:0] raw_MusicKey,
  output logic       input_PlaySong0_n,
  output logic       input_PlaySong1_n,
  output logic       input_PlayRecording_n,
  output logic       input_MakeRecording_n,
  output logic [5:0] input_MusicKey,
  output logic [3:0] press_event,
  output logic [5:0] key_event
);

  // Channel map: bits [3:0] are buttons {MakeRec, PlayRec, Song1, Song0},
  // bits [9:4] are music keys 0..5.
  localparam int NCH   = 10;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Idle level of every channel: buttons released high, keys released low.
  localparam logic [NCH-1:0] IDLE_LEVEL = {6'b000000, 4'b1111};

  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   sync_r [SYNC_STAGES];
  logic [NCH-1:0]   sync_out_s;
  logic [NCH-1:0]   db_r;
  logic [NCH-1:0]   db_next_s;
  logic [CNT_W-1:0] cnt_r      [NCH];
  logic [CNT_W-1:0] cnt_next_s [NCH];

  logic [3:0] btn_out_r;
  logic [3:0] btn_out_next_s;
  logic [3:0] btn_prev_r;
  logic [3:0] press_event_r;
  logic [5:0] key_prev_r;
  logic [5:0] key_event_r;

  assign raw_s = {raw_MusicKey, raw_MakeRecording_n, raw_PlayRecording_n,
                  raw_PlaySong1_n, raw_PlaySong0_n};

  // Synchronizer chain per channel; resets to the idle level so reset
  // release never looks like an input edge.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= IDLE_LEVEL;
      end
    end else begin
      sync_r[0] <= raw_s;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign sync_out_s = sync_r[SYNC_STAGES-1];

  // Debounce next state: count consecutive mismatched cycles, accept the
  // new level on the DEBOUNCE_CYCLES-th one, clear on any matching cycle.
  always_comb begin
    db_next_s = db_r;
    for (int i = 0; i < NCH; i++) begin
      cnt_next_s[i] = CNT_ZERO;
      if (sync_out_s[i] == db_r[i]) begin
        cnt_next_s[i] = CNT_ZERO;
      end else if (cnt_r[i] >= CNT_LAST) begin
        db_next_s[i]  = sync_out_s[i];
        cnt_next_s[i] = CNT_ZERO;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounced state and stable counters.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      db_r <= IDLE_LEVEL;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      db_r <= db_next_s;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

`ifdef MUSICBOX_INPUT_LOCKOUT_EN
  logic       owner_valid_r;
  logic       owner_valid_next_s;
  logic [1:0] owner_idx_r;
  logic [1:0] owner_idx_next_s;
  logic [3:0] blocked_r;
  logic [3:0] blocked_next_s;
  logic [3:0] held_s;
  logic [3:0] cand_s;

  // Ownership arbitration: the first unmasked press claims the group; any
  // other button held while an owner exists stays masked until released.
  always_comb begin
    held_s             = ~db_next_s[3:0];
    cand_s             = held_s & ~blocked_r;
    owner_valid_next_s = owner_valid_r;
    owner_idx_next_s   = owner_idx_r;
    blocked_next_s     = blocked_r & held_s;
    if (owner_valid_r) begin
      if (!held_s[owner_idx_r]) begin
        owner_valid_next_s = 1'b0;
      end else begin
        owner_valid_next_s = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        blocked_next_s[i] = blocked_next_s[i] |
                            (held_s[i] & (2'(i) != owner_idx_r));
      end
    end else begin
      if (cand_s[3]) begin
        owner_valid_next_s = 1'b1;
        owner_idx_next_s   = 2'd3;
      end else if (cand_s[2]) begin
        owner_valid_next_s = 1'b1;
        owner_idx_next_s   = 2'd2;
      end else if (cand_s[1]) begin
        owner_valid_next_s = 1'b1;
        owner_idx_next_s   = 2'd1;
      end else if (cand_s[0]) begin
        owner_valid_next_s = 1'b1;
        owner_idx_next_s   = 2'd0;
      end else begin
        owner_valid_next_s = 1'b0;
        owner_idx_next_s   = owner_idx_r;
      end
      // Simultaneous losers are masked until they are released.
      for (int i = 0; i < 4; i++) begin
        blocked_next_s[i] = blocked_next_s[i] |
                            (cand_s[i] & owner_valid_next_s &
                             (2'(i) != owner_idx_next_s));
      end
    end
    btn_out_next_s = db_next_s[3:0] | blocked_next_s;
  end

  // Ownership and mask registers.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      owner_valid_r <= 1'b0;
      owner_idx_r   <= 2'd0;
      blocked_r     <= 4'b0000;
    end else begin
      owner_valid_r <= owner_valid_next_s;
      owner_idx_r   <= owner_idx_next_s;
      blocked_r     <= blocked_next_s;
    end
  end
`else
  // Each button output follows its own debounced state.
  always_comb begin
    btn_out_next_s = db_next_s[3:0];
  end
`endif

  // Output levels and single-cycle press/key pulses, one cycle after the
  // debounced level change.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_out_r     <= 4'b1111;
      btn_prev_r    <= 4'b1111;
      press_event_r <= 4'b0000;
      key_prev_r    <= 6'b000000;
      key_event_r   <= 6'b000000;
    end else begin
      btn_out_r     <= btn_out_next_s;
      btn_prev_r    <= btn_out_r;
      press_event_r <= btn_prev_r & ~btn_out_r;
      key_prev_r    <= db_r[9:4];
      key_event_r   <= db_r[9:4] & ~key_prev_r;
    end
  end

  assign input_PlaySong0_n     = btn_out_r[0];
  assign input_PlaySong1_n     = btn_out_r[1];
  assign input_PlayRecording_n = btn_out_r[2];
  assign input_MakeRecording_n = btn_out_r[3];
  assign input_MusicKey        = db_r[9:4];
  assign press_event           = press_event_r;
  assign key_event             = key_event_r;

endmodule

// File: tb/tb_music_box_input_conditioner.sv
// Self-checking bench for music_box_input_conditioner with
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Stimulus is driven on the falling
// edge; expected outputs are queued per cycle and compared 1 time unit
// after each rising edge.
module tb_music_box_input_conditioner;

  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int LAT = SYN + DEB;

  logic       clock_50Mhz = 1'b0;
  logic       reset_n;
  logic       raw_PlaySong0_n;
  logic       raw_PlaySong1_n;
  logic       raw_PlayRecording_n;
  logic       raw_MakeRecording_n;
  logic [5:0] raw_MusicKey;
  logic       input_PlaySong0_n;
  logic       input_PlaySong1_n;
  logic       input_PlayRecording_n;
  logic       input_MakeRecording_n;
  logic [5:0] input_MusicKey;
  logic [3:0] press_event;
  logic [5:0] key_event;

  music_box_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYN)
  ) dut (
    .clock_50Mhz          (clock_50Mhz),
    .reset_n              (reset_n),
    .raw_PlaySong0_n      (raw_PlaySong0_n),
    .raw_PlaySong1_n      (raw_PlaySong1_n),
    .raw_PlayRecording_n  (raw_PlayRecording_n),
    .raw_MakeRecording_n  (raw_MakeRecording_n),
    .raw_MusicKey         (raw_MusicKey),
    .input_PlaySong0_n    (input_PlaySong0_n),
    .input_PlaySong1_n    (input_PlaySong1_n),
    .input_PlayRecording_n(input_PlayRecording_n),
    .input_MakeRecording_n(input_MakeRecording_n),
    .input_MusicKey       (input_MusicKey),
    .press_event          (press_event),
    .key_event            (key_event)
  );

  always #10 clock_50Mhz = ~clock_50Mhz;

  typedef struct {
    logic [3:0] lvl_btn;
    logic [5:0] lvl_key;
    logic [3:0] press;
    logic [5:0] kev;
    string      nm;
  } exp_t;

  typedef struct {
    logic [3:0] b;
    logic [5:0] k;
    logic [3:0] eb;
    logic [5:0] ek;
    logic [3:0] ep;
    logic [5:0] ekv;
    string      nm;
  } vec_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] cur_btn;
  logic [5:0] cur_key;
  vec_t       tbl[11];

  // Drive one cycle of inputs and queue what the outputs must show after
  // the next rising edge.
  task automatic step(input logic rst, input logic [3:0] b, input logic [5:0] k,
                      input logic [3:0] eb, input logic [5:0] ek,
                      input logic [3:0] ep, input logic [5:0] ekv, input string nm);
    exp_t e;
    reset_n = rst;
    {raw_MakeRecording_n, raw_PlayRecording_n, raw_PlaySong1_n, raw_PlaySong0_n} = b;
    raw_MusicKey = k;
    e.lvl_btn = eb;
    e.lvl_key = ek;
    e.press   = ep;
    e.kev     = ekv;
    e.nm      = nm;
    sb.push_back(e);
    @(negedge clock_50Mhz);
  endtask

  // Apply a clean input change held for 'hold' cycles: levels change LAT
  // cycles in, pulses appear one cycle after that.
  task automatic settle(input logic [3:0] b, input logic [5:0] k, input int hold,
                        input logic [3:0] eb, input logic [5:0] ek,
                        input logic [3:0] ep, input logic [5:0] ekv, input string nm);
    for (int j = 1; j <= hold; j++) begin
      step(1'b1, b, k,
           (j >= LAT) ? eb : cur_btn,
           (j >= LAT) ? ek : cur_key,
           (j == LAT + 1) ? ep : 4'b0000,
           (j == LAT + 1) ? ekv : 6'b000000,
           nm);
    end
    cur_btn = eb;
    cur_key = ek;
  endtask

  // Output monitor: pop one expectation per clock and compare.
  initial begin : monitor
    exp_t       e;
    logic [3:0] ob;
    forever begin
      @(posedge clock_50Mhz);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ob = {input_MakeRecording_n, input_PlayRecording_n,
              input_PlaySong1_n, input_PlaySong0_n};
        checks++;
        if ({ob, input_MusicKey} !== {e.lvl_btn, e.lvl_key}) begin
          failures++;
          $display("FAIL %s levels: got btn=%b key=%b, want btn=%b key=%b",
                   e.nm, ob, input_MusicKey, e.lvl_btn, e.lvl_key);
        end
        checks++;
        if ({press_event, key_event} !== {e.press, e.kev}) begin
          failures++;
          $display("FAIL %s events: got press=%b key=%b, want press=%b key=%b",
                   e.nm, press_event, key_event, e.press, e.kev);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset_n             = 1'b0;
    raw_PlaySong0_n     = 1'b1;
    raw_PlaySong1_n     = 1'b1;
    raw_PlayRecording_n = 1'b1;
    raw_MakeRecording_n = 1'b1;
    raw_MusicKey        = 6'b000000;
    cur_btn             = 4'b1111;
    cur_key             = 6'b000000;

    //        raw btn   raw key    lvl btn   lvl key    press     key_event
    tbl[0]  = '{4'b1110, 6'b000000, 4'b1110, 6'b000000, 4'b0001, 6'b000000, "ps0_press"};
    tbl[1]  = '{4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "ps0_release"};
    tbl[2]  = '{4'b1111, 6'b001000, 4'b1111, 6'b001000, 4'b0000, 6'b001000, "key3_on"};
    tbl[3]  = '{4'b1111, 6'b101001, 4'b1111, 6'b101001, 4'b0000, 6'b100001, "key0_5_on"};
    tbl[4]  = '{4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "keys_off"};
    tbl[5]  = '{4'b1101, 6'b000000, 4'b1101, 6'b000000, 4'b0010, 6'b000000, "ps1_press"};
    tbl[6]  = '{4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "ps1_release"};
    tbl[7]  = '{4'b1011, 6'b111111, 4'b1011, 6'b111111, 4'b0100, 6'b111111, "pr_and_keys"};
    tbl[8]  = '{4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "pr_keys_off"};
    tbl[9]  = '{4'b0111, 6'b000000, 4'b0111, 6'b000000, 4'b1000, 6'b000000, "mr_press"};
    tbl[10] = '{4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "mr_release"};

    // Reset state.
    @(negedge clock_50Mhz);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "reset");
    end

    // Clean presses/releases from the table.
    for (int i = 0; i < 11; i++) begin
      settle(tbl[i].b, tbl[i].k, 9, tbl[i].eb, tbl[i].ek, tbl[i].ep, tbl[i].ekv, tbl[i].nm);
    end

    // Key glitch of DEB-1 cycles is ignored.
    for (int j = 1; j <= 3; j++) begin
      step(1'b1, 4'b1111, 6'b001000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "glitch3");
    end
    for (int j = 1; j <= 10; j++) begin
      step(1'b1, 4'b1111, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "glitch3_after");
    end

    // Key pulse of exactly DEB cycles is accepted, then released DEB later.
    for (int j = 1; j <= 14; j++) begin
      step(1'b1, 4'b1111, (j <= 4) ? 6'b000010 : 6'b000000,
           4'b1111, (j >= 6 && j <= 9) ? 6'b000010 : 6'b000000,
           4'b0000, (j == 7) ? 6'b000010 : 6'b000000, "pulse4");
    end

    // MakeRecording bounces for 10 cycles, then holds low from cycle 11.
    for (int j = 1; j <= 20; j++) begin
      step(1'b1,
           (j <= 10 && (j % 2 == 0)) ? 4'b1111 : 4'b0111, 6'b000000,
           (j >= 16) ? 4'b0111 : 4'b1111, 6'b000000,
           (j == 17) ? 4'b1000 : 4'b0000, 6'b000000, "mr_bounce");
    end
    cur_btn = 4'b0111;
    settle(4'b1111, 6'b000000, 9, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "mr_bounce_rel");

    // Reset mid-debounce discards the partial count; no pulse at release.
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 4'b1011, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "pr_pre_rst");
    end
    for (int j = 1; j <= 2; j++) begin
      step(1'b0, 4'b1011, 6'b000000, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "pr_in_rst");
    end
    settle(4'b1011, 6'b000000, 9, 4'b1011, 6'b000000, 4'b0100, 6'b000000, "pr_post_rst");
    settle(4'b1111, 6'b000000, 9, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "pr_release");

    // PlaySong1 and MakeRecording pressed in the same cycle.
`ifdef MUSICBOX_INPUT_LOCKOUT_EN
    settle(4'b0101, 6'b000000, 9, 4'b0111, 6'b000000, 4'b1000, 6'b000000, "lock_both");
    settle(4'b1101, 6'b000000, 9, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "lock_mr_rel");
`else
    settle(4'b0101, 6'b000000, 9, 4'b0101, 6'b000000, 4'b1010, 6'b000000, "both_press");
    settle(4'b1101, 6'b000000, 9, 4'b1101, 6'b000000, 4'b0000, 6'b000000, "both_mr_rel");
`endif
    settle(4'b1111, 6'b000000, 9, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "all_rel");
    settle(4'b1101, 6'b000000, 9, 4'b1101, 6'b000000, 4'b0010, 6'b000000, "ps1_repress");
    settle(4'b1111, 6'b000000, 9, 4'b1111, 6'b000000, 4'b0000, 6'b000000, "ps1_rerelease");

    // Every queued expectation must have been consumed.
    repeat (2) @(negedge clock_50Mhz);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
